mips_control_fsm: RTL and testbench
===================================

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 The block SHALL have parameter MEM_WAIT_EN, default 1, meaning 1 = honour mem_ready wait states and 0 = treat mem_ready as constant 1.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port opcode, input, 6 bits: instruction[31:26] from the IR.
REQ-005 The block SHALL have port mem_ready, input, 1 bit: memory completed the access this cycle.
REQ-006 The block SHALL have ports ALUSrcA (2), ALUSrcB (4) and ALUOp (2), all outputs, driving the ALU operand muxes and the ALU control.
REQ-007 The block SHALL have 1-bit outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst and RegWrite, plus PCSource as a 2-bit output.
REQ-008 The block SHALL have port illegal_op, output, 1 bit: one-cycle pulse on an unsupported opcode.
REQ-009 The block SHALL have port state_o, output, 4 bits: current state encoding, for debug.

Function
REQ-010 The block SHALL implement the states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC and ADDI_WB.
REQ-011 Encodings SHALL be:
- ALUSrcA: 00 = PC, 01 = A.
- ALUSrcB: 0 = B, 1 = constant 4, 2 = sign-extend, 3 = sign-extend<<2.
- ALUOp: 00 = add, 01 = sub, 10 = funct.
- PCSource: 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-012 Outputs SHALL be Moore-decoded from the state register only, except that PCWrite and IRWrite in FETCH are qualified by mem_ready.
REQ-013 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=1, ALUOp=00, PCSource=00, and PCWrite=IRWrite=mem_ready; it SHALL stay in FETCH while mem_ready=0 and go to DECODE when it is 1.
REQ-014 DECODE SHALL drive ALUSrcA=00, ALUSrcB=3 and ALUOp=00 (branch target precompute).
REQ-015 DECODE SHALL dispatch on opcode:
- 000000 -> R_EXEC.
- 100011 (lw) or 101011 (sw) -> MEM_ADDR.
- 000100 -> BRANCH.
- 000010 -> JUMP.
- 001000 -> ADDI_EXEC.
- any other value -> FETCH, with illegal_op=1 for exactly that one cycle.
REQ-016 MEM_ADDR SHALL drive ALUSrcA=01, ALUSrcB=2, ALUOp=00, then go to MEM_READ (lw) or MEM_WRITE (sw) based on the opcode, which is held stable by the IR.
REQ-017 MEM_READ SHALL drive MemRead=1 and IorD=1, hold while mem_ready=0, and go to MEM_WB on mem_ready=1; MEM_WB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0, then go to FETCH.
REQ-018 MEM_WRITE SHALL drive MemWrite=1 and IorD=1, hold while mem_ready=0, and go to FETCH on mem_ready=1.
REQ-019 R_EXEC SHALL drive ALUSrcA=01, ALUSrcB=0, ALUOp=10, then go to R_WB; R_WB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0, then go to FETCH.
REQ-020 BRANCH SHALL drive ALUSrcA=01, ALUSrcB=0, ALUOp=01, PCWriteCond=1, PCSource=01, then go to FETCH.
REQ-021 JUMP SHALL drive PCWrite=1 and PCSource=10, then go to FETCH.
REQ-022 ADDI_EXEC SHALL drive ALUSrcA=01, ALUSrcB=2, ALUOp=00, then go to ADDI_WB; ADDI_WB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, then go to FETCH.
REQ-023 Any output not listed for a state SHALL be 0 in that state.
REQ-024 Instruction latency in cycles (with mem_ready=1) SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-025 When MEM_WAIT_EN=0, every mem_ready wait SHALL complete in one cycle.
REQ-026 An unreachable state encoding SHALL transition to FETCH on the next edge, with all outputs 0 while in it.

Reset
REQ-027 While reset=1 at a rising edge, the state SHALL become FETCH; reset SHALL take priority over every transition, including mid-wait in MEM_READ or MEM_WRITE.
REQ-028 While reset is high, all 1-bit outputs and illegal_op SHALL be forced to 0 and all select outputs to 0, so no write can occur during reset.
REQ-029 The first cycle after reset deasserts SHALL be FETCH with normal FETCH outputs.

Structure
REQ-030 Package mips_ctrl_pkg SHALL hold:
- the state enum;
- the opcode constants;
- the ALUSrcA, ALUSrcB, ALUOp and PCSource encoding enums, shared with the ALU operand mux block.
REQ-031 One combinational sub-module, mips_ctrl_decode, SHALL map state and mem_ready to the control outputs; the top level holds only the state register and next-state logic.

Verification
REQ-032 Reset mid-wait: reset=1 for 1 cycle while in MEM_READ with mem_ready=0 -> next state FETCH and MemRead=0 during reset.
REQ-033 lw with mem_ready=1: opcode=100011 -> sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB (5 cycles); RegWrite=1 and MemtoReg=1 only in MEM_WB.
REQ-034 Fetch wait: mem_ready held 0 for 3 cycles in FETCH -> state stays FETCH, PCWrite=IRWrite=0; on the 4th cycle mem_ready=1 -> PCWrite=IRWrite=1, then DECODE.
REQ-035 Branch: opcode=000100 -> BRANCH with ALUOp=01, ALUSrcB=0, PCWriteCond=1, PCSource=01, then FETCH; beq completes in 3 cycles.
REQ-036 Illegal opcode: opcode=111111 in DECODE -> illegal_op=1 for exactly 1 cycle, next state FETCH, and no RegWrite, MemWrite or PCWrite asserted.
REQ-037 With MEM_WAIT_EN=0 and mem_ready tied 0: sw completes in 4 cycles, with MemWrite=1 for exactly 1 cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multicycle MIPS control path: state encoding, opcode
// constants, datapath select encodings and the bundled control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {
        SRCA_PC  = 2'b00,
        SRCA_REG = 2'b01
    } alu_src_a_e;

    typedef enum logic [3:0] {
        SRCB_REG      = 4'd0,
        SRCB_FOUR     = 4'd1,
        SRCB_SEXT     = 4'd2,
        SRCB_SEXT_SH2 = 4'd3
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    // Complete control word produced by the decoder for one cycle.
    typedef struct packed {
        alu_src_a_e alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        pc_src_e    pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore output decoder: maps the current state to the control word. Only the
// FETCH-cycle PC and IR writes look at the memory handshake.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    input  logic   reset,
    output ctrl_t  ctrl
);

    // Per-state control word; everything not named for a state stays 0.
    always_comb begin
        // NOTE: assigning a full default before the case keeps every field
        // driven on every path, so no latch can be inferred.
        ctrl = '0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_a = SRCA_PC;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.pc_source = PC_ALU;
                    ctrl.pc_write  = mem_ready;
                    ctrl.ir_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_a = SRCA_PC;
                    ctrl.alu_src_b = SRCB_SEXT_SH2;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    ctrl.alu_src_a = SRCA_REG;
                    ctrl.alu_src_b = SRCB_SEXT;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_READ: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                S_R_EXEC: begin
                    ctrl.alu_src_a = SRCA_REG;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = SRCA_REG;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.alu_op        = ALU_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PC_JUMP;
                end
                S_ADDI_WB: begin
                    ctrl.reg_write = 1'b1;
                end
                default: begin
                    // Unreachable encodings leave the all-zero word in place.
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main control: state register, next-state logic and the
// illegal-opcode pulse. Output decoding lives in mips_ctrl_decode.
module mips_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] ALUSrcA,
    output logic [3:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_e state;
    logic   illegal_q;
    logic   mem_ok;
    ctrl_t  ctrl;

    // With wait states disabled every memory access completes immediately.
    assign mem_ok = MEM_WAIT_EN ? mem_ready : 1'b1;

    // State register with next-state dispatch; the illegal flag is set on
    // the DECODE -> FETCH abort so it pulses for the following cycle only.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values regardless of statement order.
        if (reset) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                S_FETCH:     if (mem_ok) state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_RTYPE:     state <= S_R_EXEC;
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        OP_ADDI:      state <= S_ADDI_EXEC;
                        default: begin
                            state     <= S_FETCH;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR:  state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (mem_ok) state <= S_MEM_WB;
                S_MEM_WB:    state <= S_FETCH;
                S_MEM_WRITE: if (mem_ok) state <= S_FETCH;
                S_R_EXEC:    state <= S_R_WB;
                S_R_WB:      state <= S_FETCH;
                S_BRANCH:    state <= S_FETCH;
                S_JUMP:      state <= S_FETCH;
                S_ADDI_EXEC: state <= S_ADDI_WB;
                S_ADDI_WB:   state <= S_FETCH;
                default:     state <= S_FETCH;
            endcase
        end
    end

    mips_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (mem_ok),
        .reset     (reset),
        .ctrl      (ctrl)
    );

    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;

    // Reset is synchronous, so the flag flop may still hold 1 during the
    // reset cycle; mask it so nothing is signalled while reset is high.
    assign illegal_op = illegal_q & ~reset;
    assign state_o    = state;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Bench for mips_control_fsm: cycle-by-cycle vector table fed through a
// scoreboard queue, plus a hand sequence on a no-wait-state instance.
module tb_mips_control_fsm;
    import mips_ctrl_pkg::*;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        logic [3:0] st;
        logic [1:0] a;
        logic [3:0] b;
        logic [1:0] aop;
        logic [1:0] pcs;
        logic [9:0] fl;
    } vec_t;

    // Flag order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite illegal_op
    localparam logic [9:0] F_NONE     = 10'b0000000000;
    localparam logic [9:0] F_FRDY     = 10'b1001010000;
    localparam logic [9:0] F_FWAIT    = 10'b0001000000;
    localparam logic [9:0] F_MEMRD    = 10'b0011000000;
    localparam logic [9:0] F_MEMWB    = 10'b0000001010;
    localparam logic [9:0] F_MEMWR    = 10'b0010100000;
    localparam logic [9:0] F_RWB      = 10'b0000000110;
    localparam logic [9:0] F_BR       = 10'b0100000000;
    localparam logic [9:0] F_J        = 10'b1000000000;
    localparam logic [9:0] F_AWB      = 10'b0000000010;
    localparam logic [9:0] F_ILL_WAIT = 10'b0001000001;
    localparam logic [9:0] F_ILL_RDY  = 10'b1001010001;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, AI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111, JAL = 6'b000011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b100011;
    logic       mem_ready = 1'b1;

    logic [1:0] ALUSrcA, ALUOp, PCSource;
    logic [3:0] ALUSrcB, state_o;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, illegal_op;

    logic [1:0] nw_ALUSrcA, nw_ALUOp, nw_PCSource;
    logic [3:0] nw_ALUSrcB, nw_state_o;
    logic nw_PCWrite, nw_PCWriteCond, nw_IorD, nw_MemRead, nw_MemWrite, nw_IRWrite, nw_MemtoReg, nw_RegDst, nw_RegWrite, nw_illegal_op;

    int n_vec = 0;
    int n_err = 0;
    int vec_idx = 0;
    vec_t vt[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    mips_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .PCSource(PCSource), .illegal_op(illegal_op), .state_o(state_o)
    );

    mips_control_fsm #(.MEM_WAIT_EN(1'b0)) dut_nw (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(1'b0),
        .ALUSrcA(nw_ALUSrcA), .ALUSrcB(nw_ALUSrcB), .ALUOp(nw_ALUOp),
        .PCWrite(nw_PCWrite), .PCWriteCond(nw_PCWriteCond), .IorD(nw_IorD),
        .MemRead(nw_MemRead), .MemWrite(nw_MemWrite), .IRWrite(nw_IRWrite),
        .MemtoReg(nw_MemtoReg), .RegDst(nw_RegDst), .RegWrite(nw_RegWrite),
        .PCSource(nw_PCSource), .illegal_op(nw_illegal_op), .state_o(nw_state_o)
    );

    wire [23:0] act_main = {state_o, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                            PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                            IRWrite, MemtoReg, RegDst, RegWrite, illegal_op};
    wire [23:0] act_nw   = {nw_state_o, nw_ALUSrcA, nw_ALUSrcB, nw_ALUOp, nw_PCSource,
                            nw_PCWrite, nw_PCWriteCond, nw_IorD, nw_MemRead, nw_MemWrite,
                            nw_IRWrite, nw_MemtoReg, nw_RegDst, nw_RegWrite, nw_illegal_op};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [5:0] o, input logic m,
                                input logic [3:0] s, input logic [1:0] a, input logic [3:0] b,
                                input logic [1:0] u, input logic [1:0] p, input logic [9:0] f);
        vec_t v;
        v.rst = r; v.op = o; v.rdy = m; v.st = s;
        v.a = a; v.b = b; v.aop = u; v.pcs = p; v.fl = f;
        return v;
    endfunction

    function automatic logic [23:0] exp_bus(input vec_t v);
        return {v.st, v.a, v.b, v.aop, v.pcs, v.fl};
    endfunction

    // Scoreboard consumer: each negedge compares the oldest pending vector.
    always @(negedge clk) begin
        vec_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("vec%0d", vec_idx), {8'h0, act_main}, {8'h0, exp_bus(e)});
            vec_idx++;
        end
    end

    initial begin
        vec_t nw_exp[5];
        int   mw;

        // reset
        vt.push_back(mk(1, LW, 1, S_FETCH,     0, 0, 0, 0, F_NONE));
        // lw, no waits: 5 cycles
        vt.push_back(mk(0, LW, 1, S_FETCH,     0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(0, LW, 1, S_DECODE,    0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, LW, 1, S_MEM_ADDR,  1, 2, 0, 0, F_NONE));
        vt.push_back(mk(0, LW, 1, S_MEM_READ,  0, 0, 0, 0, F_MEMRD));
        vt.push_back(mk(0, LW, 1, S_MEM_WB,    0, 0, 0, 0, F_MEMWB));
        // R-type: 4 cycles
        vt.push_back(mk(0, RT, 1, S_FETCH,     0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(0, RT, 1, S_DECODE,    0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, RT, 1, S_R_EXEC,    1, 0, 2, 0, F_NONE));
        vt.push_back(mk(0, RT, 1, S_R_WB,      0, 0, 0, 0, F_RWB));
        // beq: 3 cycles
        vt.push_back(mk(0, BQ, 1, S_FETCH,     0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(0, BQ, 1, S_DECODE,    0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, BQ, 1, S_BRANCH,    1, 0, 1, 1, F_BR));
        // j: 3 cycles
        vt.push_back(mk(0, JJ, 1, S_FETCH,     0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(0, JJ, 1, S_DECODE,    0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, JJ, 1, S_JUMP,      0, 0, 0, 2, F_J));
        // addi: 4 cycles
        vt.push_back(mk(0, AI, 1, S_FETCH,     0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(0, AI, 1, S_DECODE,    0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, AI, 1, S_ADDI_EXEC, 1, 2, 0, 0, F_NONE));
        vt.push_back(mk(0, AI, 1, S_ADDI_WB,   0, 0, 0, 0, F_AWB));
        // sw with one write wait state
        vt.push_back(mk(0, SW, 1, S_FETCH,     0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(0, SW, 1, S_DECODE,    0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, SW, 1, S_MEM_ADDR,  1, 2, 0, 0, F_NONE));
        vt.push_back(mk(0, SW, 0, S_MEM_WRITE, 0, 0, 0, 0, F_MEMWR));
        vt.push_back(mk(0, SW, 1, S_MEM_WRITE, 0, 0, 0, 0, F_MEMWR));
        // fetch wait for 3 cycles, then illegal opcode
        vt.push_back(mk(0, BAD, 0, S_FETCH,    0, 1, 0, 0, F_FWAIT));
        vt.push_back(mk(0, BAD, 0, S_FETCH,    0, 1, 0, 0, F_FWAIT));
        vt.push_back(mk(0, BAD, 0, S_FETCH,    0, 1, 0, 0, F_FWAIT));
        vt.push_back(mk(0, BAD, 1, S_FETCH,    0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(0, BAD, 1, S_DECODE,   0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, LW, 0, S_FETCH,     0, 1, 0, 0, F_ILL_WAIT));
        vt.push_back(mk(0, LW, 0, S_FETCH,     0, 1, 0, 0, F_FWAIT));
        // lw, reset while waiting in MEM_READ
        vt.push_back(mk(0, LW, 1, S_FETCH,     0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(0, LW, 1, S_DECODE,    0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, LW, 1, S_MEM_ADDR,  1, 2, 0, 0, F_NONE));
        vt.push_back(mk(0, LW, 0, S_MEM_READ,  0, 0, 0, 0, F_MEMRD));
        vt.push_back(mk(1, LW, 0, S_MEM_READ,  0, 0, 0, 0, F_NONE));
        // sw, reset while waiting in MEM_WRITE
        vt.push_back(mk(0, SW, 1, S_FETCH,     0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(0, SW, 1, S_DECODE,    0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, SW, 1, S_MEM_ADDR,  1, 2, 0, 0, F_NONE));
        vt.push_back(mk(1, SW, 0, S_MEM_WRITE, 0, 0, 0, 0, F_NONE));
        // reset in DECODE with an illegal opcode suppresses the pulse
        vt.push_back(mk(0, BAD, 1, S_FETCH,    0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(1, BAD, 1, S_DECODE,   0, 0, 0, 0, F_NONE));
        vt.push_back(mk(0, JAL, 1, S_FETCH,    0, 1, 0, 0, F_FRDY));
        vt.push_back(mk(0, JAL, 1, S_DECODE,   0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, RT, 1, S_FETCH,     0, 1, 0, 0, F_ILL_RDY));
        vt.push_back(mk(0, RT, 1, S_DECODE,    0, 3, 0, 0, F_NONE));
        vt.push_back(mk(0, RT, 1, S_R_EXEC,    1, 0, 2, 0, F_NONE));

        // First edge with reset held puts the state register into FETCH.
        @(posedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1;
            reset     = vt[i].rst;
            opcode    = vt[i].op;
            mem_ready = vt[i].rdy;
            sb.push_back(vt[i]);
        end
        @(negedge clk);
        #1;

        // No-wait-state instance with mem_ready tied low: sw in 4 cycles.
        nw_exp[0] = mk(0, SW, 1, S_FETCH,     0, 1, 0, 0, F_FRDY);
        nw_exp[1] = mk(0, SW, 1, S_DECODE,    0, 3, 0, 0, F_NONE);
        nw_exp[2] = mk(0, SW, 1, S_MEM_ADDR,  1, 2, 0, 0, F_NONE);
        nw_exp[3] = mk(0, SW, 1, S_MEM_WRITE, 0, 0, 0, 0, F_MEMWR);
        nw_exp[4] = mk(0, SW, 1, S_FETCH,     0, 1, 0, 0, F_FRDY);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        opcode    = SW;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mw = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("nw_cycle%0d", c), {8'h0, act_nw}, {8'h0, exp_bus(nw_exp[c])});
            if (nw_MemWrite) mw++;
        end
        check("nw_memwrite_cycles", mw, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
